// File: rtl/ita_activation_ctrl_pkg.sv
// Shared types and constants for the ITA activation control slice.
package ita_package;

    localparam int unsigned N           = 16;
    localparam int unsigned ACT_LATENCY = 2;

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        GELU     = 2'd1,
        RELU     = 2'd2
    } activation_e;

    typedef logic [N-1:0][7:0] requant_oup_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } act_state_e;

endpackage

// File: rtl/ita_activation_ctrl_fifo.sv
// ita_act_fifo: power-of-two circular buffer with simultaneous push/pop.
module ita_act_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == DEPTH[AW:0]);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head reads as zero when empty so the output port has a defined reset value.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/ita_activation_ctrl.sv
// Activation job controller: sequences vectors through the datapath and buffers results.
// Optional stall counter port enabled by defining ITA_ACT_CTRL_PERF_EN.
module ita_activation_ctrl
    import ita_package::*;
#(
    parameter int unsigned N          = ita_package::N,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    input  activation_e  cfg_activation_i,
    input  logic [15:0]  cfg_len_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output activation_e  act_activation_o,
    output logic         act_calc_en_o,
    output logic         act_calc_en_q_o,
    input  requant_oup_t act_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output requant_oup_t out_data_o,
    output logic         out_last_o,
    output logic         busy_o,
    output logic         done_o
`ifdef ITA_ACT_CTRL_PERF_EN
    ,
    output logic [31:0]  stall_cnt_o
`endif
);
    localparam int unsigned DW = 8 * N;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    act_state_e  state_q;
    activation_e act_q;
    logic [15:0] len_q, cnt_q;
    logic        pipe_v_q, pipe_l_q;

    logic          accept, beat_last, pop;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   used;
    logic [DW:0]   fifo_dout;
    logic          fifo_full, fifo_empty;

    // The accept cycle is the first latency stage; pipe_*_q is the second,
    // during which the datapath result is present and pushed.
    assign used       = {1'b0, fifo_cnt} + {{CW{1'b0}}, pipe_v_q};
    assign in_ready_o = (state_q == ST_RUN) && (len_q != '0) && (used < FIFO_DEPTH[CW:0]);
    assign accept     = in_valid_i && in_ready_o;
    assign beat_last  = (cnt_q == len_q - 16'd1);
    assign pop        = out_valid_o && out_ready_i;

    assign cfg_ready_o      = (state_q == ST_IDLE);
    assign busy_o           = (state_q != ST_IDLE);
    assign act_activation_o = act_q;
    assign act_calc_en_o    = accept;
    assign act_calc_en_q_o  = pipe_v_q;
    assign out_valid_o      = !fifo_empty;
    assign out_last_o       = fifo_dout[DW];
    assign out_data_o       = fifo_dout[DW-1:0];
    assign done_o           = ((state_q == ST_RUN) && (len_q == '0)) ||
                              ((state_q == ST_DRAIN) && pop && out_last_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            act_q    <= IDENTITY;
            len_q    <= '0;
            cnt_q    <= '0;
            pipe_v_q <= 1'b0;
            pipe_l_q <= 1'b0;
        end else begin
            pipe_v_q <= accept;
            pipe_l_q <= accept && beat_last;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid_i) begin
                        act_q   <= cfg_activation_i;
                        len_q   <= cfg_len_i;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (len_q == '0) begin
                        state_q <= ST_IDLE;
                        act_q   <= IDENTITY;
                    end else if (accept) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (beat_last) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (done_o) begin
                        state_q <= ST_IDLE;
                        act_q   <= IDENTITY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ita_act_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (pipe_v_q),
        .data_i  ({pipe_l_q, act_data_i}),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

`ifdef ITA_ACT_CTRL_PERF_EN
    logic [31:0] stall_q;
    assign stall_cnt_o = stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if ((state_q == ST_IDLE) && cfg_valid_i) begin
            stall_q <= '0;
        end else if ((state_q == ST_RUN) && in_valid_i && !in_ready_o && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ita_activation_ctrl.sv
// Randomized bench for ita_activation_ctrl against a beat-queue reference model.
module tb_ita_activation_ctrl;
    import ita_package::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = $bits(requant_oup_t);

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         cfg_valid_i;
    logic         cfg_ready_o;
    activation_e  cfg_activation_i;
    logic [15:0]  cfg_len_i;
    logic         in_valid_i;
    logic         in_ready_o;
    activation_e  act_activation_o;
    logic         act_calc_en_o;
    logic         act_calc_en_q_o;
    requant_oup_t act_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    requant_oup_t out_data_o;
    logic         out_last_o;
    logic         busy_o;
    logic         done_o;
`ifdef ITA_ACT_CTRL_PERF_EN
    logic [31:0]  stall_cnt_o;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           avail;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk_i = ~clk_i;

    ita_activation_ctrl #(
        .N          (ita_package::N),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .cfg_valid_i      (cfg_valid_i),
        .cfg_ready_o      (cfg_ready_o),
        .cfg_activation_i (cfg_activation_i),
        .cfg_len_i        (cfg_len_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .act_activation_o (act_activation_o),
        .act_calc_en_o    (act_calc_en_o),
        .act_calc_en_q_o  (act_calc_en_q_o),
        .act_data_i       (act_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .out_last_o       (out_last_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
`ifdef ITA_ACT_CTRL_PERF_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // rdy_mode: 0 always ready, 1 blocked until cycle 14, 2 toggle, 3 random, 4 never
    // vld_mode: 0 always valid, 1 random, 2 valid only for the first three vectors
    task automatic run_job(input int len, input activation_e act, input int rdy_mode,
                           input int vld_mode, input int stop_after);
        int           acc = 0, popped = 0, k = 0, stalls = 0;
        logic         pend_v = 1'b0, prev_acc = 1'b0, done_seen = 1'b0;
        logic [W-1:0] pend_vec = '0, cur_vec;
        logic         exp_rdy, exp_ov, exp_done, exp_busy, in_run, pop;
        exp_q.delete();
        while (!done_seen) begin
            @(posedge clk_i); #1;
            act_data_i       = pend_v ? pend_vec : rand_vec();
            cfg_valid_i      = (k == 0);
            cfg_len_i        = 16'(len);
            cfg_activation_i = act;
            cur_vec          = rand_vec();
            case (vld_mode)
                0:       in_valid_i = (k >= 1);
                1:       in_valid_i = (k >= 1) && ($urandom_range(0, 3) != 0);
                default: in_valid_i = (k >= 1) && (acc < 3);
            endcase
            case (rdy_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (k >= 14);
                2:       out_ready_i = k[0];
                3:       out_ready_i = ($urandom_range(0, 2) != 0);
                default: out_ready_i = 1'b0;
            endcase
            @(negedge clk_i);
            exp_busy = (k >= 1);
            in_run   = (k >= 1) && ((len == 0) ? (k == 1) : (acc < len));
            exp_rdy  = (k >= 1) && (len != 0) && (acc < len) && ((acc - popped) < int'(DEPTH));
            exp_ov   = (exp_q.size() != 0) && (exp_q[0].avail <= k);
            exp_done = ((len == 0) && (k == 1)) || (exp_ov && out_ready_i && exp_q[0].last);
            check_eq("cfg_ready", cfg_ready_o, !exp_busy);
            check_eq("busy", busy_o, exp_busy);
            check_eq("in_ready", in_ready_o, exp_rdy);
            check_eq("calc_en", act_calc_en_o, in_valid_i && exp_rdy);
            check_eq("calc_en_q", act_calc_en_q_o, prev_acc);
            check_eq("out_valid", out_valid_o, exp_ov);
            check_eq("done", done_o, exp_done);
            if (exp_busy) check_eq("activation", act_activation_o, act);
            if (exp_ov) begin
                check_eq("out_data", out_data_o, exp_q[0].data);
                check_eq("out_last", out_last_o, exp_q[0].last);
            end
            if (in_run && in_valid_i && !exp_rdy) stalls++;
            pop      = exp_ov && out_ready_i;
            prev_acc = in_valid_i && exp_rdy;
            pend_v   = prev_acc;
            pend_vec = cur_vec;
            if (prev_acc) begin
                exp_q.push_back('{data: cur_vec, last: (acc == len - 1), avail: k + ACT_LATENCY});
                acc++;
            end
            if (pop) begin
                void'(exp_q.pop_front());
                popped++;
            end
            if (exp_done) done_seen = 1'b1;
            k++;
            if (stop_after > 0 && k >= stop_after) break;
            if (k > 400) begin
                check_eq("job_timeout", 1'b0, 1'b1);
                break;
            end
        end
        cfg_valid_i = 1'b0;
        in_valid_i  = 1'b0;
`ifdef ITA_ACT_CTRL_PERF_EN
        check_eq("stall_cnt", stall_cnt_o, 32'(stalls));
`else
        if (stalls < 0) $display("unreachable");
`endif
    endtask

    initial begin
        rst_ni           = 1'b0;
        cfg_valid_i      = 1'b0;
        cfg_activation_i = IDENTITY;
        cfg_len_i        = '0;
        in_valid_i       = 1'b0;
        out_ready_i      = 1'b0;
        act_data_i       = '0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_cfg_ready", cfg_ready_o, 1'b1);
        check_eq("rst_in_ready", in_ready_o, 1'b0);
        check_eq("rst_calc_en", act_calc_en_o, 1'b0);
        check_eq("rst_calc_en_q", act_calc_en_q_o, 1'b0);
        check_eq("rst_out_valid", out_valid_o, 1'b0);
        check_eq("rst_out_last", out_last_o, 1'b0);
        check_eq("rst_out_data", out_data_o, '0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_activation", act_activation_o, IDENTITY);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        run_job(8, RELU, 0, 0, 0);
        run_job(10, IDENTITY, 1, 0, 0);
        run_job(0, GELU, 0, 0, 0);
        run_job(16, GELU, 2, 0, 0);

        // Three beats buffered and the job incomplete, then reset.
        run_job(8, RELU, 4, 2, 7);
        check_eq("pre_rst_out_valid", out_valid_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid_o, 1'b0);
        check_eq("midrst_busy", busy_o, 1'b0);
        check_eq("midrst_done", done_o, 1'b0);
        check_eq("midrst_activation", act_activation_o, IDENTITY);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        run_job(5, GELU, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            run_job(int'($urandom_range(1, 20)), activation_e'($urandom_range(0, 2)), 3, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ita_activation_ctrl.md
ITA_ACTIVATION_CTRL -- requirements
Module: ita_activation_ctrl

Interface
REQ-001 SHALL have parameter N, default N from ita_package, lanes per vector.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=4).
REQ-003 SHALL have port clk_i  input  1  clock; single clock domain.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports cfg_valid_i/cfg_ready_o  in/out  1  job-config handshake.
REQ-006 SHALL have ports cfg_activation_i  input  activation_e  and cfg_len_i  input  16  vectors in job.
REQ-007 SHALL have ports in_valid_i/in_ready_o  in/out  1  input-vector handshake (data goes direct to datapath).
REQ-008 SHALL have ports act_activation_o  output  activation_e, act_calc_en_o  output  1, act_calc_en_q_o  output  1  datapath control.
REQ-009 SHALL have port act_data_i  input  requant_oup_t  datapath result.
REQ-010 SHALL have ports out_valid_o/out_ready_i  out/in  1, out_data_o  output  requant_oup_t, out_last_o  output  1.
REQ-011 SHALL have ports busy_o  output  1 and done_o  output  1 (one-cycle pulse).

Function
REQ-012 SHALL implement FSM IDLE->RUN->DRAIN->IDLE; cfg_ready_o=1 only in IDLE.
REQ-013 On cfg handshake SHALL latch activation and len into registers, clear beat counter, enter RUN; len=0 SHALL go to IDLE next cycle with done_o pulse and no output beats.
REQ-014 Input accept = RUN && in_valid_i && in_ready_o; in_ready_o=1 iff RUN && (fifo_count + inflight) < FIFO_DEPTH.
REQ-015 act_calc_en_o SHALL equal accept (combinational); act_calc_en_q_o SHALL equal accept delayed 1 cycle.
REQ-016 SHALL track inflight with 2-stage valid/last shift register; result at act_data_i SHALL be written to FIFO exactly 2 cycles after accept.
REQ-017 Beat with counter == len-1 SHALL carry last=1; after that accept SHALL move RUN->DRAIN.
REQ-018 DRAIN SHALL exit to IDLE in cycle where last beat pops from FIFO (out_valid_o && out_ready_i && out_last_o), pulsing done_o same cycle.
REQ-019 act_activation_o SHALL hold latched value through DRAIN until IDLE.
REQ-020 FIFO SHALL support simultaneous push and pop, count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 out_valid_o = FIFO not empty; out_data_o/out_last_o = head entry, stable while out_valid_o && !out_ready_i.
REQ-022 Credit rule SHALL guarantee no FIFO overflow; push on full SHALL never occur (assertion).
REQ-023 busy_o = (state != IDLE).
REQ-024 Full-throughput: with out_ready_i=1 constant, one vector accepted per cycle.

Reset
REQ-025 rst_ni low SHALL asynchronously force IDLE, counters, pointers, inflight bits to 0; act_activation_o=IDENTITY.
REQ-026 Output reset values: cfg_ready_o=1 after release, in_ready_o=0, act_calc_en_o=0, act_calc_en_q_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, done_o=0.
REQ-027 Reset mid-job SHALL discard inflight and buffered beats with no done_o.

Configuration
REQ-028 Macro ITA_ACT_CTRL_PERF_EN defined: SHALL add output stall_cnt_o [31:0], counting RUN cycles with in_valid_i && !in_ready_o, cleared on cfg handshake, saturating at all-ones.
REQ-029 Macro undefined: port and counter SHALL be absent; behaviour otherwise identical.

Structure
REQ-030 activation_e, requant_oup_t, N, and new localparam ACT_LATENCY=2 SHALL reside in ita_package.
REQ-031 Output buffer SHALL be sub-module ita_act_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-032 cfg len=8 RELU, in_valid=1, out_ready=1 -> 8 accepts in 8 consecutive cycles, first out_valid 2 cycles after first accept, out_last on beat 8, done_o once.
REQ-033 len=10, out_ready=0 -> in_ready drops after exactly 4 accepts (FIFO_DEPTH=4); releasing out_ready resumes, 10 beats delivered in order.
REQ-034 len=0 -> done_o 1 cycle after cfg handshake, no out_valid, busy returns 0.
REQ-035 out_ready toggling 1/0 each cycle, len=16 GELU -> no FIFO overflow assertion, data order preserved, out_data stable while stalled.
REQ-036 rst_ni asserted with 3 beats buffered -> out_valid=0 immediately, next cfg accepted, no stray done_o.
REQ-037 With ITA_ACT_CTRL_PERF_EN, scenario REQ-033 -> stall_cnt_o equals stalled in_valid cycles counted by bench.
